axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
AXI4 slave responder backed by on-chip memory: the far end of the axi_engine master. Accepts AW/W bursts and commits them to RAM with per-byte strobes; accepts AR bursts and returns R beats. Used as a loopback memory model for engine bring-up and as a scratchpad target in the fabric. One outstanding write and one outstanding read; the two channels run independently.

Parameters:
ADDR_WIDTH, 33, byte address width
DATA_WIDTH, 256, data bus width (256 HBM, 512 DDR4); BYTES=DATA_WIDTH/8, ADDR_LSB=log2(BYTES)
ID_WIDTH, 6, AXI ID width
LEN_WIDTH, 8, burst length field width
MEM_DEPTH_LOG2, 10, log2 of RAM depth in DATA_WIDTH words

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axi_AWVALID  in  1  write address valid
s_axi_AWADDR  in  ADDR_WIDTH  write byte address
s_axi_AWID  in  ID_WIDTH  write ID
s_axi_AWLEN  in  LEN_WIDTH  beats-1
s_axi_AWSIZE  in  3  beat size
s_axi_AWBURST  in  2  burst type
s_axi_AWREADY  out  1  write address accepted
s_axi_WVALID  in  1  write data valid
s_axi_WDATA  in  DATA_WIDTH  write data
s_axi_WSTRB  in  DATA_WIDTH/8  byte enables
s_axi_WLAST  in  1  last write beat
s_axi_WID  in  ID_WIDTH  ignored
s_axi_WREADY  out  1  write data accepted
s_axi_BVALID  out  1  write response valid
s_axi_BRESP  out  2  00 OKAY, 10 SLVERR
s_axi_BID  out  ID_WIDTH  echo of AWID
s_axi_BREADY  in  1  response accepted
s_axi_ARVALID  in  1  read address valid
s_axi_ARADDR  in  ADDR_WIDTH  read byte address
s_axi_ARID  in  ID_WIDTH  read ID
s_axi_ARLEN  in  LEN_WIDTH  beats-1
s_axi_ARSIZE  in  3  beat size
s_axi_ARBURST  in  2  burst type
s_axi_ARREADY  out  1  read address accepted
s_axi_RVALID  out  1  read data valid
s_axi_RDATA  out  DATA_WIDTH  read data
s_axi_RLAST  out  1  last read beat
s_axi_RID  out  ID_WIDTH  echo of ARID
s_axi_RRESP  out  2  00 OKAY, 10 SLVERR
s_axi_RREADY  in  1  read data accepted
Master LOCK/CACHE/PROT/QOS/REGION outputs are left unconnected at integration.

Behaviour:
- Reset (async assert, sync release): all outputs 0, both FSMs to IDLE, beat counters 0. RAM contents are not cleared. Reset mid-burst abandons the burst; no B/R is issued for it.
- Word index = addr[ADDR_LSB+MEM_DEPTH_LOG2-1:ADDR_LSB]; higher bits are ignored (aliasing). Index wraps modulo depth.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: AWREADY=1 (registered, first asserted the cycle after reset release). On AW handshake: latch addr/id/len/burst; size_ok = (AWSIZE==ADDR_LSB); clear err; enter W_DATA; AWREADY=0, WREADY=1.
- W_DATA, each W handshake: if size_ok, write bytes where WSTRB=1. INCR (01) and WRAP (10) advance the index by 1; FIXED (00) holds it. err |= (WLAST != (beat==len)). On beat==len: WREADY=0, enter W_RESP with BVALID=1, BID=latched id, BRESP = SLVERR if (!size_ok | err), else OKAY.
- W_RESP: hold BVALID/BID/BRESP stable until BREADY; then W_IDLE (AWREADY=1 next cycle). WLAST early does not end the burst; beat count governs.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE).
- R_IDLE: ARREADY=1. On AR handshake: latch fields, size_ok; ARREADY=0; enter R_FETCH.
- R_FETCH: issue RAM read (1-cycle registered latency). Next cycle RVALID=1, RDATA=word, RLAST=(beat==len), RID=latched id, RRESP=SLVERR if !size_ok (RDATA=0 in that case).
- R_DATA: hold all R outputs stable until RREADY. On handshake: if last, enter R_IDLE; else advance the index (same burst rules) and enter R_FETCH. Throughput is 1 beat per 2 cycles.
- Same-cycle write and read-fetch to the same index: the read returns old data (read-first).
- Write and read channels never stall each other; AW and AR handshakes in the same cycle are both accepted.

Decomposition:
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR constants, FSM state enums.
- Sub-module axi_resp_ram: simple dual-port RAM (port A byte-enable write, port B registered read), DATA_WIDTH x 2^MEM_DEPTH_LOG2.

Test Plan:
- AW addr 0x40, LEN 3, SIZE 5, INCR; 4 W beats 0xA0..0xA3, full strobe, WLAST on beat 3 -> BVALID, BRESP 00, BID=AWID; AR same -> 4 R beats 0xA0..0xA3, RLAST on beat 3 only.
- Write 0x40 with 0xFF..FF, then WSTRB=0x0000_000F with data 0 -> readback low 4 bytes 0, rest FF.
- FIXED burst LEN 2 to 0x80, data 1,2,3 -> read 0x80 returns 3.
- AWSIZE 3'b011 (DATA_WIDTH 256) -> BRESP 10, RAM unchanged; ARSIZE 3'b011 -> RRESP 10 on every beat, RDATA 0.
- WLAST asserted on beat 1 of a LEN 3 burst -> 4 beats accepted, BRESP 10. BREADY held low for 5 cycles -> BVALID and BID stable, AWREADY 0 throughout.
- Assert reset during R_DATA with RREADY low -> RVALID 0 immediately; ARREADY 1 the cycle after release; previously written data still readable.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared constants and state types for the AXI memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
    typedef enum logic [1:0] {StRIdle, StRFetch, StRData} r_state_e;

    // INCR and WRAP both step the word index; only FIXED holds it.
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM: port A byte-enable write, port B registered read.
// A same-cycle write and read of one word returns the old contents.
module axi_resp_ram #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [ADDR_BITS-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Port A: commit only the strobed bytes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Port B: one-cycle registered read, held when not enabled.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip RAM. One outstanding write and one outstanding
// read; the write and read paths are independent FSMs sharing only the RAM.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 33,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ID_WIDTH       = 6,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axi_AWVALID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [LEN_WIDTH-1:0]    s_axi_AWLEN,
    input  logic [2:0]              s_axi_AWSIZE,
    input  logic [1:0]              s_axi_AWBURST,
    output logic                    s_axi_AWREADY,
    input  logic                    s_axi_WVALID,
    input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                    s_axi_WLAST,
    input  logic [ID_WIDTH-1:0]     s_axi_WID,
    output logic                    s_axi_WREADY,
    output logic                    s_axi_BVALID,
    output logic [1:0]              s_axi_BRESP,
    output logic [ID_WIDTH-1:0]     s_axi_BID,
    input  logic                    s_axi_BREADY,
    input  logic                    s_axi_ARVALID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [LEN_WIDTH-1:0]    s_axi_ARLEN,
    input  logic [2:0]              s_axi_ARSIZE,
    input  logic [1:0]              s_axi_ARBURST,
    output logic                    s_axi_ARREADY,
    output logic                    s_axi_RVALID,
    output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic                    s_axi_RLAST,
    output logic [ID_WIDTH-1:0]     s_axi_RID,
    output logic [1:0]              s_axi_RRESP,
    input  logic                    s_axi_RREADY
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB  = $clog2(BYTES);
    localparam logic [2:0]  FULL_SIZE = 3'(ADDR_LSB);

    // Write path state
    w_state_e                  w_state;
    logic                      aw_ready, w_ready, b_valid;
    logic [1:0]                b_resp;
    logic [ID_WIDTH-1:0]       w_id, b_id;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [LEN_WIDTH-1:0]      w_beat, w_len;
    logic [1:0]                w_burst;
    logic                      w_size_ok, w_err;

    // Read path state
    r_state_e                  r_state;
    logic                      ar_ready, r_valid, r_last;
    logic [1:0]                r_resp;
    logic [ID_WIDTH-1:0]       r_id;
    logic [MEM_DEPTH_LOG2-1:0] r_idx;
    logic [LEN_WIDTH-1:0]      r_beat, r_len;
    logic [1:0]                r_burst;
    logic                      r_size_ok;

    logic                      w_fire, w_last_beat, ram_we, ram_re;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    // Address bits outside the word index alias; WID is not used by AXI4.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_WID, s_axi_AWADDR, s_axi_ARADDR};

    assign w_fire      = w_ready && s_axi_WVALID;
    assign w_last_beat = (w_beat == w_len);
    assign ram_we      = w_fire && w_size_ok;
    assign ram_re      = (r_state == StRFetch);

    axi_resp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_idx),
        .wstrb (s_axi_WSTRB),
        .wdata (s_axi_WDATA),
        .re    (ram_re),
        .raddr (r_idx),
        .rdata (ram_rdata)
    );

    // Write FSM: accept AW, sink beats until the count is reached, then respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state   <= StWIdle;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
            b_id      <= '0;
            w_id      <= '0;
            w_idx     <= '0;
            w_beat    <= '0;
            w_len     <= '0;
            w_burst   <= BURST_FIXED;
            w_size_ok <= 1'b0;
            w_err     <= 1'b0;
        end else begin
            unique case (w_state)
                StWIdle: begin
                    if (aw_ready && s_axi_AWVALID) begin
                        w_idx     <= s_axi_AWADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
                        w_id      <= s_axi_AWID;
                        w_len     <= s_axi_AWLEN;
                        w_burst   <= s_axi_AWBURST;
                        w_size_ok <= (s_axi_AWSIZE == FULL_SIZE);
                        w_beat    <= '0;
                        w_err     <= 1'b0;
                        aw_ready  <= 1'b0;
                        w_ready   <= 1'b1;
                        w_state   <= StWData;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                StWData: begin
                    if (w_fire) begin
                        if (burst_advances(w_burst)) begin
                            w_idx <= w_idx + 1'b1;
                        end
                        w_beat <= w_beat + 1'b1;
                        w_err  <= w_err | (s_axi_WLAST != w_last_beat);
                        // Beat count, not WLAST, ends the burst.
                        if (w_last_beat) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_id    <= w_id;
                            b_resp  <= (!w_size_ok || w_err || !s_axi_WLAST) ?
                                       RESP_SLVERR : RESP_OKAY;
                            w_state <= StWResp;
                        end
                    end
                end
                StWResp: begin
                    if (s_axi_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_state  <= StWIdle;
                    end
                end
                default: w_state <= StWIdle;
            endcase
        end
    end

    // Read FSM: one RAM fetch per beat, then hold the beat until RREADY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StRIdle;
            ar_ready  <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_resp    <= RESP_OKAY;
            r_id      <= '0;
            r_idx     <= '0;
            r_beat    <= '0;
            r_len     <= '0;
            r_burst   <= BURST_FIXED;
            r_size_ok <= 1'b0;
        end else begin
            unique case (r_state)
                StRIdle: begin
                    if (ar_ready && s_axi_ARVALID) begin
                        r_idx     <= s_axi_ARADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
                        r_id      <= s_axi_ARID;
                        r_len     <= s_axi_ARLEN;
                        r_burst   <= s_axi_ARBURST;
                        r_size_ok <= (s_axi_ARSIZE == FULL_SIZE);
                        r_beat    <= '0;
                        ar_ready  <= 1'b0;
                        r_state   <= StRFetch;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                StRFetch: begin
                    r_valid <= 1'b1;
                    r_last  <= (r_beat == r_len);
                    r_resp  <= r_size_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state <= StRData;
                end
                StRData: begin
                    if (s_axi_RREADY) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            ar_ready <= 1'b1;
                            r_state  <= StRIdle;
                        end else begin
                            if (burst_advances(r_burst)) begin
                                r_idx <= r_idx + 1'b1;
                            end
                            r_beat  <= r_beat + 1'b1;
                            r_state <= StRFetch;
                        end
                    end
                end
                default: r_state <= StRIdle;
            endcase
        end
    end

    assign s_axi_AWREADY = aw_ready;
    assign s_axi_WREADY  = w_ready;
    assign s_axi_BVALID  = b_valid;
    assign s_axi_BRESP   = b_resp;
    assign s_axi_BID     = b_id;
    assign s_axi_ARREADY = ar_ready;
    assign s_axi_RVALID  = r_valid;
    assign s_axi_RLAST   = r_last;
    assign s_axi_RID     = r_id;
    assign s_axi_RRESP   = r_resp;
    // RAM output register holds across the beat; gate to zero when idle or mis-sized.
    assign s_axi_RDATA   = (r_valid && r_size_ok) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: burst write/read, strobes, FIXED
// bursts, size errors, early WLAST, B back-pressure and mid-burst reset.
module tb_axi_mem_responder;

    localparam int unsigned AW = 33;
    localparam int unsigned DW = 256;
    localparam int unsigned IW = 6;
    localparam int unsigned LW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            s_axi_AWVALID = 1'b0;
    logic [AW-1:0]   s_axi_AWADDR = '0;
    logic [IW-1:0]   s_axi_AWID = '0;
    logic [LW-1:0]   s_axi_AWLEN = '0;
    logic [2:0]      s_axi_AWSIZE = '0;
    logic [1:0]      s_axi_AWBURST = '0;
    logic            s_axi_AWREADY;
    logic            s_axi_WVALID = 1'b0;
    logic [DW-1:0]   s_axi_WDATA = '0;
    logic [DW/8-1:0] s_axi_WSTRB = '0;
    logic            s_axi_WLAST = 1'b0;
    logic [IW-1:0]   s_axi_WID = '0;
    logic            s_axi_WREADY;
    logic            s_axi_BVALID;
    logic [1:0]      s_axi_BRESP;
    logic [IW-1:0]   s_axi_BID;
    logic            s_axi_BREADY = 1'b0;
    logic            s_axi_ARVALID = 1'b0;
    logic [AW-1:0]   s_axi_ARADDR = '0;
    logic [IW-1:0]   s_axi_ARID = '0;
    logic [LW-1:0]   s_axi_ARLEN = '0;
    logic [2:0]      s_axi_ARSIZE = '0;
    logic [1:0]      s_axi_ARBURST = '0;
    logic            s_axi_ARREADY;
    logic            s_axi_RVALID;
    logic [DW-1:0]   s_axi_RDATA;
    logic            s_axi_RLAST;
    logic [IW-1:0]   s_axi_RID;
    logic [1:0]      s_axi_RRESP;
    logic            s_axi_RREADY = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_AWVALID (s_axi_AWVALID),
        .s_axi_AWADDR  (s_axi_AWADDR),
        .s_axi_AWID    (s_axi_AWID),
        .s_axi_AWLEN   (s_axi_AWLEN),
        .s_axi_AWSIZE  (s_axi_AWSIZE),
        .s_axi_AWBURST (s_axi_AWBURST),
        .s_axi_AWREADY (s_axi_AWREADY),
        .s_axi_WVALID  (s_axi_WVALID),
        .s_axi_WDATA   (s_axi_WDATA),
        .s_axi_WSTRB   (s_axi_WSTRB),
        .s_axi_WLAST   (s_axi_WLAST),
        .s_axi_WID     (s_axi_WID),
        .s_axi_WREADY  (s_axi_WREADY),
        .s_axi_BVALID  (s_axi_BVALID),
        .s_axi_BRESP   (s_axi_BRESP),
        .s_axi_BID     (s_axi_BID),
        .s_axi_BREADY  (s_axi_BREADY),
        .s_axi_ARVALID (s_axi_ARVALID),
        .s_axi_ARADDR  (s_axi_ARADDR),
        .s_axi_ARID    (s_axi_ARID),
        .s_axi_ARLEN   (s_axi_ARLEN),
        .s_axi_ARSIZE  (s_axi_ARSIZE),
        .s_axi_ARBURST (s_axi_ARBURST),
        .s_axi_ARREADY (s_axi_ARREADY),
        .s_axi_RVALID  (s_axi_RVALID),
        .s_axi_RDATA   (s_axi_RDATA),
        .s_axi_RLAST   (s_axi_RLAST),
        .s_axi_RID     (s_axi_RID),
        .s_axi_RRESP   (s_axi_RRESP),
        .s_axi_RREADY  (s_axi_RREADY)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic aw_send(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [LW-1:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        s_axi_AWADDR = addr; s_axi_AWID = id; s_axi_AWLEN = len;
        s_axi_AWSIZE = size; s_axi_AWBURST = burst; s_axi_AWVALID = 1'b1;
        while (!s_axi_AWREADY && n < 20) begin @(posedge clk); #1; n++; end
        check("awready", s_axi_AWREADY, 1);
        @(posedge clk); #1;
        s_axi_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                          input logic last);
        int n = 0;
        s_axi_WDATA = data; s_axi_WSTRB = strb; s_axi_WLAST = last; s_axi_WVALID = 1'b1;
        while (!s_axi_WREADY && n < 20) begin @(posedge clk); #1; n++; end
        check("wready", s_axi_WREADY, 1);
        @(posedge clk); #1;
        s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] resp, input logic [IW-1:0] id);
        int n = 0;
        while (!s_axi_BVALID && n < 20) begin @(posedge clk); #1; n++; end
        check("bvalid", s_axi_BVALID, 1);
        check("bresp", s_axi_BRESP, resp);
        check("bid", s_axi_BID, id);
        s_axi_BREADY = 1'b1;
        @(posedge clk); #1;
        s_axi_BREADY = 1'b0;
        check("bvalid_drop", s_axi_BVALID, 0);
        check("awready_after_b", s_axi_AWREADY, 1);
    endtask

    task automatic ar_send(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [LW-1:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        s_axi_ARADDR = addr; s_axi_ARID = id; s_axi_ARLEN = len;
        s_axi_ARSIZE = size; s_axi_ARBURST = burst; s_axi_ARVALID = 1'b1;
        while (!s_axi_ARREADY && n < 20) begin @(posedge clk); #1; n++; end
        check("arready", s_axi_ARREADY, 1);
        @(posedge clk); #1;
        s_axi_ARVALID = 1'b0;
    endtask

    task automatic r_recv(input logic [DW-1:0] data, input logic last,
                          input logic [1:0] resp, input logic [IW-1:0] id);
        int n = 0;
        while (!s_axi_RVALID && n < 20) begin @(posedge clk); #1; n++; end
        check("rvalid", s_axi_RVALID, 1);
        check("rdata", s_axi_RDATA, data);
        check("rlast", s_axi_RLAST, last);
        check("rresp", s_axi_RRESP, resp);
        check("rid", s_axi_RID, id);
        s_axi_RREADY = 1'b1;
        @(posedge clk); #1;
        s_axi_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] hi_ff;
        hi_ff = '1;
        hi_ff[31:0] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_axi_AWREADY, 0);
        check("rst_wready", s_axi_WREADY, 0);
        check("rst_bvalid", s_axi_BVALID, 0);
        check("rst_arready", s_axi_ARREADY, 0);
        check("rst_rvalid", s_axi_RVALID, 0);
        check("rst_rdata", s_axi_RDATA, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_awready", s_axi_AWREADY, 1);
        check("rel_arready", s_axi_ARREADY, 1);

        // INCR burst of 4 to 0x40 and read it back
        aw_send(33'h40, 6'd5, 8'd3, 3'd5, 2'b01);
        for (int i = 0; i < 4; i++) w_send(DW'(8'hA0 + i), '1, i == 3);
        check("wready_drop", s_axi_WREADY, 0);
        b_recv(2'b00, 6'd5);
        ar_send(33'h40, 6'd9, 8'd3, 3'd5, 2'b01);
        for (int i = 0; i < 4; i++) r_recv(DW'(8'hA0 + i), i == 3, 2'b00, 6'd9);

        // Byte strobes: all-ones then clear low 4 bytes
        aw_send(33'h40, 6'd1, 8'd0, 3'd5, 2'b01);
        w_send('1, '1, 1'b1);
        b_recv(2'b00, 6'd1);
        aw_send(33'h40, 6'd2, 8'd0, 3'd5, 2'b01);
        w_send('0, 32'h0000_000F, 1'b1);
        b_recv(2'b00, 6'd2);
        ar_send(33'h40, 6'd3, 8'd0, 3'd5, 2'b01);
        r_recv(hi_ff, 1'b1, 2'b00, 6'd3);

        // FIXED burst: last beat wins
        aw_send(33'h80, 6'd4, 8'd2, 3'd5, 2'b00);
        for (int i = 0; i < 3; i++) w_send(DW'(i + 1), '1, i == 2);
        b_recv(2'b00, 6'd4);
        ar_send(33'h80, 6'd6, 8'd0, 3'd5, 2'b01);
        r_recv(DW'(3), 1'b1, 2'b00, 6'd6);

        // Narrow size: write rejected, RAM unchanged; read returns SLVERR and zero
        aw_send(33'h40, 6'd7, 8'd0, 3'd3, 2'b01);
        w_send(DW'(16'h1234), '1, 1'b1);
        b_recv(2'b10, 6'd7);
        ar_send(33'h40, 6'd8, 8'd0, 3'd5, 2'b01);
        r_recv(hi_ff, 1'b1, 2'b00, 6'd8);
        ar_send(33'h40, 6'd10, 8'd1, 3'd3, 2'b01);
        r_recv('0, 1'b0, 2'b10, 6'd10);
        r_recv('0, 1'b1, 2'b10, 6'd10);

        // Early WLAST: all 4 beats still taken, SLVERR; B held under back-pressure
        aw_send(33'hC0, 6'd11, 8'd3, 3'd5, 2'b01);
        for (int i = 0; i < 4; i++) w_send(DW'(8'hB0 + i), '1, i == 1);
        check("wready_after_early_last", s_axi_WREADY, 0);
        for (int c = 0; c < 5; c++) begin
            check("hold_bvalid", s_axi_BVALID, 1);
            check("hold_bid", s_axi_BID, 6'd11);
            check("hold_bresp", s_axi_BRESP, 2'b10);
            check("hold_awready", s_axi_AWREADY, 0);
            @(posedge clk); #1;
        end
        b_recv(2'b10, 6'd11);

        // Reset while a read beat is waiting on RREADY
        ar_send(33'h80, 6'd12, 8'd1, 3'd5, 2'b01);
        @(posedge clk); #1;
        check("pre_rst_rvalid", s_axi_RVALID, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rvalid", s_axi_RVALID, 0);
        check("async_rst_arready", s_axi_ARREADY, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rel2_arready_0", s_axi_ARREADY, 0);
        @(posedge clk); #1;
        check("rel2_arready_1", s_axi_ARREADY, 1);
        check("rel2_rvalid", s_axi_RVALID, 0);
        check("rel2_bvalid", s_axi_BVALID, 0);
        ar_send(33'h80, 6'd13, 8'd0, 3'd5, 2'b01);
        r_recv(DW'(3), 1'b1, 2'b00, 6'd13);
        ar_send(33'h40, 6'd14, 8'd0, 3'd5, 2'b01);
        r_recv(hi_ff, 1'b1, 2'b00, 6'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
